// File: rtl/lut_sweep_capture.sv
// lut_sweep_capture: steps a 4-input LUT through x = 0..15, captures y into a
// 16-bit truth table and compares it against a golden table latched at start.
module lut_sweep_capture #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] golden,
    output logic [3:0]  lut_x,
    input  logic        lut_y,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic        match
);
    // state | meaning
    // IDLE  | waiting for start; truth_table/match hold last result
    // RUN   | stepping lut_x, capturing lut_y every SETTLE_CYCLES cycles
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic [15:0] gold_q, gold_d;
    logic        match_q, match_d;
    logic        done_q, done_d;
    logic        sample_edge;

    assign sample_edge = (state_q == RUN) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 4'd0;
            cnt_q   <= 8'd0;
            tt_q    <= 16'd0;
            gold_q  <= 16'd0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            gold_q  <= gold_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (sample_edge && (x_q == 4'hF)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        gold_d  = gold_q;
        match_d = match_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                x_d     = 4'd0;
                cnt_d   = 8'd0;
                tt_d    = 16'd0;
                match_d = 1'b0;
                gold_d  = golden;
            end
        end else if (sample_edge) begin
            tt_d[x_q] = lut_y;
            cnt_d     = 8'd0;
            // x wraps 15 -> 0 on the final sample, so IDLE starts at x = 0
            x_d       = x_q + 4'd1;
            if (x_q == 4'hF) begin
                done_d  = 1'b1;
                match_d = (tt_d == gold_q);
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        lut_x       = x_q;
        busy        = (state_q == RUN);
        done        = done_q;
        truth_table = tt_q;
        match       = match_q;
    end

endmodule

// File: tb/tb_lut_sweep_capture.sv
// Bench for lut_sweep_capture: two instances (SETTLE_CYCLES 1 and 3) driving
// behavioural LUTs, table-driven directed sweeps, random sweeps and corner sequences.
module tb_lut_sweep_capture;

    logic        clk;
    logic        rst;
    logic        start1, start3;
    logic [15:0] golden1, golden3;
    logic [3:0]  x1, x3;
    logic        y1, y3;
    logic        busy1, busy3, done1, done3, match1, match3;
    logic [15:0] tt1, tt3;
    int          mode1, mode3;
    logic [15:0] tbl1, tbl3;

    int tests = 0;
    int fails = 0;

    // LUT under test: mode 1 = XOR of x, mode 2 = AND of x, otherwise arbitrary table
    function automatic logic lut_fn(int mode, logic [15:0] tbl, logic [3:0] x);
        case (mode)
            1:       return ^x;
            2:       return &x;
            default: return tbl[x];
        endcase
    endfunction

    function automatic logic [15:0] model_tt(int mode, logic [15:0] tbl);
        logic [15:0] r;
        r = '0;
        for (int x = 0; x < 16; x++) r[x] = lut_fn(mode, tbl, 4'(x));
        return r;
    endfunction

    assign y1 = lut_fn(mode1, tbl1, x1);
    assign y3 = lut_fn(mode3, tbl3, x3);

    lut_sweep_capture #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .golden(golden1), .lut_x(x1), .lut_y(y1),
        .busy(busy1), .done(done1), .truth_table(tt1), .match(match1)
    );

    lut_sweep_capture #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .golden(golden3), .lut_x(x3), .lut_y(y3),
        .busy(busy3), .done(done3), .truth_table(tt3), .match(match3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive_start(input int inst, input logic v, input logic [15:0] g);
        if (inst == 1) begin
            start1 = v; golden1 = g;
        end else begin
            start3 = v; golden3 = g;
        end
    endtask

    task automatic sample(input int inst, output logic [3:0] ox, output logic ob, output logic od,
                          output logic [15:0] ott, output logic om);
        if (inst == 1) begin
            ox = x1; ob = busy1; od = done1; ott = tt1; om = match1;
        end else begin
            ox = x3; ob = busy3; od = done3; ott = tt3; om = match3;
        end
    endtask

    // One sweep from an idle DUT; optional start re-pulse (golden FFFF) when lut_x reaches pulse_x
    task automatic run_sweep(input int inst, input int mode, input logic [15:0] tbl,
                             input logic [15:0] gold, input logic [15:0] exp_tt,
                             input logic exp_m, input int pulse_x, input string nm);
        int          s;
        int          xerr;
        logic [3:0]  ox;
        logic        ob, od, om;
        logic [15:0] ott;
        s    = (inst == 1) ? 1 : 3;
        xerr = 0;
        if (inst == 1) begin
            mode1 = mode; tbl1 = tbl;
        end else begin
            mode3 = mode; tbl3 = tbl;
        end
        @(negedge clk);
        drive_start(inst, 1'b1, gold);
        for (int k = 0; k <= 16 * s; k++) begin
            @(negedge clk);
            drive_start(inst, 1'b0, 16'($urandom));
            sample(inst, ox, ob, od, ott, om);
            if (k < 16 * s) begin
                if (int'(ox) != k / s || ob !== 1'b1 || od !== 1'b0) xerr++;
            end else begin
                check({nm, ".done"}, {31'd0, od}, 32'd1);
                check({nm, ".busy_end"}, {31'd0, ob}, 32'd0);
                check({nm, ".x_wrap"}, {28'd0, ox}, 32'd0);
                check({nm, ".table"}, {16'd0, ott}, {16'd0, exp_tt});
                check({nm, ".match"}, {31'd0, om}, {31'd0, exp_m});
            end
            if (pulse_x >= 0 && k == pulse_x * s) drive_start(inst, 1'b1, 16'hFFFF);
        end
        check({nm, ".xtrace"}, 32'(xerr), 32'd0);
        @(negedge clk);
        sample(inst, ox, ob, od, ott, om);
        check({nm, ".done_pulse"}, {31'd0, od}, 32'd0);
        check({nm, ".hold"}, {15'd0, om, ott}, {15'd0, exp_m, exp_tt});
    endtask

    typedef struct {
        int          inst;
        int          mode;
        logic [15:0] tbl;
        logic [15:0] gold;
        logic [15:0] exp_tt;
        logic        exp_m;
        int          pulse_x;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [3:0]  ox;
        logic        ob, od, om;
        logic [15:0] ott;
        int          cnt;
        int          errs;

        vecs.push_back('{1, 1, 16'h0000, 16'h6996, 16'h6996, 1'b1, -1, "xor_ok"});
        vecs.push_back('{1, 1, 16'h0000, 16'h6997, 16'h6996, 1'b0, -1, "xor_bad"});
        vecs.push_back('{3, 2, 16'h0000, 16'h8000, 16'h8000, 1'b1, -1, "and_s3"});
        vecs.push_back('{1, 1, 16'h0000, 16'h6996, 16'h6996, 1'b1, 5, "repulse"});
        vecs.push_back('{3, 1, 16'h0000, 16'h6996, 16'h6996, 1'b1, 5, "repulse_s3"});

        rst = 1'b1; start1 = 0; start3 = 0; golden1 = 16'hFFFF; golden3 = 16'hFFFF;
        mode1 = 1; mode3 = 1; tbl1 = 0; tbl3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.x1", {28'd0, x1}, 32'd0);
        check("rst.busy1", {31'd0, busy1}, 32'd0);
        check("rst.done1", {31'd0, done1}, 32'd0);
        check("rst.tt1", {16'd0, tt1}, 32'd0);
        check("rst.match1", {31'd0, match1}, 32'd0);
        check("rst.dut3", {8'd0, x3, busy3, done3, match3, 1'b0, tt3}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_sweep(vecs[i].inst, vecs[i].mode, vecs[i].tbl, vecs[i].gold,
                      vecs[i].exp_tt, vecs[i].exp_m, vecs[i].pulse_x, vecs[i].nm);

        for (int i = 0; i < 10; i++) begin
            logic [15:0] t, g, e;
            int          inst;
            inst = (i < 7) ? 1 : 3;
            t = 16'($urandom);
            e = model_tt(0, t);
            g = ($urandom_range(0, 1) == 1) ? e : (e ^ (16'd1 << $urandom_range(0, 15)));
            run_sweep(inst, 0, t, g, e, (e == g), -1, $sformatf("rand%0d", i));
        end

        // reset while lut_x = 7
        mode1 = 1;
        @(negedge clk);
        start1 = 1'b1; golden1 = 16'h6996;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        check("rstmid.x7", {28'd0, x1}, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.outs", {10'd0, x1, busy1, done1, match1, tt1}, 32'd0);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) cnt++;
        end
        check("rstmid.quiet", 32'(cnt), 32'd0);
        run_sweep(1, 1, 16'h0000, 16'h6996, 16'h6996, 1'b1, -1, "after_rst");

        // start held high: each restart is accepted on the done cycle
        @(negedge clk);
        start1 = 1'b1; golden1 = 16'h6996;
        cnt = 0; errs = 0;
        for (int t = 0; t < 51; t++) begin
            @(negedge clk);
            sample(1, ox, ob, od, ott, om);
            if (od !== (t % 17 == 16) || ob !== (t % 17 != 16)) errs++;
            if (t % 17 == 0 && ott !== 16'h0000) errs++;
            if (od === 1'b1) begin
                cnt++;
                if (ott !== 16'h6996 || om !== 1'b1) errs++;
            end
        end
        start1 = 1'b0;
        check("b2b.done_count", 32'(cnt), 32'd3);
        check("b2b.errors", 32'(errs), 32'd0);
        @(negedge clk);
        check("b2b.idle", {31'd0, busy1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
